seq_detect_ctrl: RTL

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

---
 rtl/seq_detect_pkg.sv | 14 +
 rtl/seq_window_cmp.sv | 31 +++
 rtl/seq_detect_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/seq_detect_pkg.sv
// Shared definitions for the serial pattern detector: controller states and
// default sizing.
package seq_detect_pkg;

  localparam int MAXLEN_DEF = 8;
  localparam int CNTW_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_window_cmp.sv
// Combinational window compare.
// The newest bit (bit_in) sits at window[0]. Older bits follow it from the
// history, so pattern[len-1] lines up with the oldest bit of the window.
// Bits at or above len are masked out of the compare.
module seq_window_cmp
  import seq_detect_pkg::*;
#(
  parameter int MAXLEN = MAXLEN_DEF,
  parameter int LENW   = $clog2(MAXLEN) + 1
) (
  input  logic [MAXLEN-2:0] history,
  input  logic              bit_in,
  input  logic [MAXLEN-1:0] pattern,
  input  logic [LENW-1:0]   len,
  output logic              hit
);

  logic [MAXLEN-1:0] window;
  logic [MAXLEN-1:0] mask;

  // build the candidate window and the length mask, then compare
  always_comb begin
    window = {history, bit_in};
    mask   = '0;
    for (int i = 0; i < MAXLEN; i++) begin
      mask[i] = (LENW'(i) < len);
    end
    hit = (((window ^ pattern) & mask) == '0);
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector with run control.
// A start pulse latches the configuration and opens a run. Accepted bits are
// shifted into a history register. A match needs at least len bits of history
// that have not already been consumed. In non-overlapping mode a match empties
// the fill count, so the bits of a matched window are never reused.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int MAXLEN = MAXLEN_DEF,
  parameter int CNTW   = CNTW_DEF
) (
  input  logic                      clk,
  input  logic                      clear_n,
  input  logic [MAXLEN-1:0]         cfg_pattern,
  input  logic [$clog2(MAXLEN):0]   cfg_len,
  input  logic                      cfg_overlap,
  input  logic [CNTW-1:0]           cfg_target,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      bit_in,
  input  logic                      bit_valid,
  output logic                      bit_ready,
  output logic                      match,
  output logic [CNTW-1:0]           match_count,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int LENW = $clog2(MAXLEN) + 1;

  state_e            state;
  state_e            state_nxt;
  logic [MAXLEN-2:0] hist;
  logic [LENW-1:0]   fill;
  logic [MAXLEN-1:0] pat_q;
  logic [LENW-1:0]   len_q;
  logic              ovl_q;
  logic [CNTW-1:0]   tgt_q;

  logic              len_ok;
  logic              accept;
  logic              win_hit;
  logic              hit;
  logic              tgt_hit;
  logic              start_ok;
  logic [CNTW-1:0]   cnt_inc;
  logic [LENW-1:0]   fill_inc;

  seq_window_cmp #(
    .MAXLEN (MAXLEN),
    .LENW   (LENW)
  ) u_cmp (
    .history (hist),
    .bit_in  (bit_in),
    .pattern (pat_q),
    .len     (len_q),
    .hit     (win_hit)
  );

  assign len_ok   = (cfg_len >= LENW'(2)) && (cfg_len <= LENW'(MAXLEN));
  assign start_ok = start && (state != RUN);
  assign accept   = bit_valid && (state == RUN);
  // a window only counts once enough unconsumed bits sit behind bit_in
  assign hit      = accept && win_hit && (fill >= (len_q - LENW'(1)));
  // the count saturates at all-ones so an unbounded run never wraps
  assign cnt_inc  = (&match_count) ? match_count : match_count + CNTW'(1);
  assign tgt_hit  = hit && (tgt_q != '0) && (cnt_inc == tgt_q);
  assign fill_inc = (fill < len_q) ? fill + LENW'(1) : fill;

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign bit_ready = busy;

  // state register
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic; an illegal length goes straight to DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = len_ok ? RUN : DONE;
        end
      end
      RUN: begin
        if (tgt_hit || abort) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // configuration capture, history shifting, match pulse and counting
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      hist        <= '0;
      fill        <= '0;
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      tgt_q       <= '0;
      match       <= 1'b0;
      match_count <= '0;
      err         <= 1'b0;
    end else begin
      match <= 1'b0;
      if (start_ok) begin
        pat_q       <= cfg_pattern;
        len_q       <= cfg_len;
        ovl_q       <= cfg_overlap;
        tgt_q       <= cfg_target;
        hist        <= '0;
        fill        <= '0;
        match_count <= '0;
        err         <= !len_ok;
      end else if (accept) begin
        hist <= {hist[MAXLEN-3:0], bit_in};
        if (hit) begin
          match       <= 1'b1;
          match_count <= cnt_inc;
          fill        <= ovl_q ? fill_inc : '0;
        end else begin
          fill <= fill_inc;
        end
      end
    end
  end

endmodule
